q_add_mult_unit: RTL and testbench
==================================

// Module: q_add_mult_unit
// PURPOSE
// - Registered sign-magnitude fixed-point arithmetic unit: one add or one multiply per cycle.
// - Operands and result are Q(N-Q-1).Q sign-magnitude: MSB = sign (1 = negative), N-1 magnitude bits.
// - Arithmetic primitive for iterative datapaths (e.g. z^2 + c fractal cores); callers negate by flipping the MSB.
// PARAMETERS
// - Q  default 12  number of fractional bits
// - N  default 16  total bits including sign; requires N-1 > Q
// PORTS
// - clk        in   1  clock; all state updates on rising edge
// - rst_n      in   1  reset: synchronous, active-low
// - in_valid   in   1  operation request this cycle
// - op         in   1  0 = add (a+b), 1 = multiply (a*b)
// - a          in   N  operand A, sign-magnitude
// - b          in   N  operand B, sign-magnitude
// - out_valid  out  1  result/ovf valid this cycle
// - result     out  N  sign-magnitude result
// - ovf        out  1  magnitude overflow of the completed operation
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): out_valid=0, result=0, ovf=0; in-flight op discarded.
// - Latency 1: inputs sampled at edge k with in_valid=1 -> result/ovf/out_valid=1 after edge k.
// - No backpressure; a new op is accepted every cycle. in_valid=0 -> out_valid=0 next cycle, result/ovf hold.
// - Let ma=a[N-2:0], mb=b[N-2:0], sa=a[N-1], sb=b[N-1].
// - Add, sa==sb: s=ma+mb (N bits); ovf=s[N-1]; magnitude=s[N-2:0]; sign=sa.
// - Add, sa!=sb: larger magnitude minus smaller; sign of the larger; never overflows.
// - Multiply: p=ma*mb (2N-2 bits); m=p>>Q (truncate toward zero);
//   ovf = any bit of m above bit N-2 set; magnitude=m[N-2:0]; sign=sa^sb.
// - Zero result (magnitude 0) always gets sign 0; equal-magnitude opposite-sign add yields 0x0.
// - Negative-zero inputs (MSB=1, magnitude 0) are treated as zero.
// - ovf reflects only the op completed in that cycle; not sticky.
// - rst_n low while in_valid high: reset wins, out_valid=0 next cycle.
// CONFIGURATION
// - Macro Q_SATURATE_EN.
// - Defined: on ovf=1, magnitude forced to all ones (2^(N-1)-1); sign per rules above.
// - Undefined: on ovf=1, magnitude wraps (truncated low N-1 bits); zero-sign rule still applies.
// - ovf is asserted identically in both builds.
// TESTING (N=16, Q=12; 1.0 = 0x1000)
// - Reset: hold rst_n=0 two cycles -> out_valid=0, result=0x0000, ovf=0.
// - Multiply: a=0x1800 (1.5), b=0x2000 (2.0), op=1 -> result=0x3000, ovf=0;
//   a=0x9800 (-1.5), b=0x2000 -> result=0xB000.
// - Add, mixed signs: a=0x1000, b=0x9800 -> 0x8800 (-0.5); a=0x1000, b=0x9000 -> 0x0000.
// - Add overflow: a=0x7000, b=0x2000 -> ovf=1; result=0x1000 wrap / 0x7FFF with Q_SATURATE_EN.
// - Multiply overflow: a=0x4000, b=0x4000 -> ovf=1; result=0x0000 wrap / 0x7FFF saturate;
//   a=0xC000, b=0x4000 -> saturate build gives 0xFFFF.
// - Back-to-back: 3 consecutive ops -> 3 consecutive out_valid cycles, in order;
//   rst_n=0 during the 2nd op -> no result for it, out_valid=0.

Source files
------------

// File: rtl/q_add_mult_unit.sv
// Registered sign-magnitude Q(N-Q-1).Q add/multiply unit with single-cycle latency.
// Build option: define Q_SATURATE_EN to clamp overflowed magnitudes to all ones instead of wrapping.
module q_add_mult_unit #(
    parameter int unsigned Q = 12,
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         ovf
);

    localparam int unsigned MW = N - 1;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned SW = PW - Q;

    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic          sa;
    logic          sb;
    logic [N-1:0]  sum_s;
    logic [PW-1:0] prod;
    logic [SW-1:0] prod_sh;
    logic [MW-1:0] mag_c;
    logic          sign_c;
    logic          ovf_c;
    logic [N-1:0]  res_c;

    logic          out_valid_d, out_valid_q;
    logic [N-1:0]  result_d,    result_q;
    logic          ovf_d,       ovf_q;

    assign ma = a[MW-1:0];
    assign mb = b[MW-1:0];
    assign sa = a[N-1];
    assign sb = b[N-1];

    // Combinational arithmetic for the operation presented this cycle.
    always_comb begin
        sum_s   = N'(ma) + N'(mb);
        prod    = PW'(ma) * PW'(mb);
        prod_sh = SW'(prod >> Q);
        mag_c   = '0;
        sign_c  = 1'b0;
        ovf_c   = 1'b0;
        if (op) begin
            mag_c  = prod_sh[MW-1:0];
            ovf_c  = |prod_sh[SW-1:MW];
            sign_c = sa ^ sb;
        end else if (sa == sb) begin
            mag_c  = sum_s[MW-1:0];
            ovf_c  = sum_s[N-1];
            sign_c = sa;
        end else if (ma >= mb) begin
            mag_c  = ma - mb;
            sign_c = sa;
        end else begin
            mag_c  = mb - ma;
            sign_c = sb;
        end
`ifdef Q_SATURATE_EN
        if (ovf_c) begin
            mag_c = '1;
        end
`endif
        // Zero is always reported as positive zero.
        if (mag_c == '0) begin
            sign_c = 1'b0;
        end
        res_c = {sign_c, mag_c};
    end

    // Next-state: capture on a request, otherwise hold result/ovf and drop valid.
    always_comb begin
        out_valid_d = in_valid;
        result_d    = result_q;
        ovf_d       = ovf_q;
        if (in_valid) begin
            result_d = res_c;
            ovf_d    = ovf_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_q_add_mult_unit.sv
// Scoreboard bench for q_add_mult_unit (N=16, Q=12); expectations follow Q_SATURATE_EN when defined.
module tb_q_add_mult_unit;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] result;
    logic        ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [15:0] last_res;

    q_add_mult_unit #(.Q(12), .N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] wrap_res, input logic [15:0] sat_res,
                         input logic ov);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
`ifdef Q_SATURATE_EN
        e.res = sat_res;
`else
        e.res = wrap_res;
`endif
        e.ovf    = ov;
        last_res = e.res;
        exp_q.push_back(e);
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 1'b0;
        a        = '0;
        b        = '0;
        last_res = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'h0);
        check("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //     op    a        b        wrap     sat      ovf
        issue(1'b1, 16'h1800, 16'h2000, 16'h3000, 16'h3000, 1'b0);
        issue(1'b1, 16'h9800, 16'h2000, 16'hB000, 16'hB000, 1'b0);
        issue(1'b0, 16'h1000, 16'h9800, 16'h8800, 16'h8800, 1'b0);
        issue(1'b0, 16'h1000, 16'h9000, 16'h0000, 16'h0000, 1'b0);
        issue(1'b0, 16'h7000, 16'h2000, 16'h1000, 16'h7FFF, 1'b1);
        issue(1'b1, 16'h4000, 16'h4000, 16'h0000, 16'h7FFF, 1'b1);
        issue(1'b1, 16'hC000, 16'h4000, 16'h0000, 16'hFFFF, 1'b1);
        issue(1'b0, 16'h8000, 16'h1234, 16'h1234, 16'h1234, 1'b0);
        issue(1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0);
        issue(1'b1, 16'h8000, 16'h9000, 16'h0000, 16'h0000, 1'b0);
        issue(1'b0, 16'h9000, 16'h9800, 16'hA800, 16'hA800, 1'b0);
        issue(1'b0, 16'h2800, 16'h9000, 16'h1800, 16'h1800, 1'b0);
        issue(1'b1, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        issue(1'b1, 16'h7FFF, 16'h1000, 16'h7FFF, 16'h7FFF, 1'b0);
        issue(1'b1, 16'h7FFF, 16'h7FFF, 16'h7FF0, 16'h7FFF, 1'b1);
        issue(1'b0, 16'h4000, 16'h3FFF, 16'h7FFF, 16'h7FFF, 1'b0);
        issue(1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h7FFF, 1'b1);
        issue(1'b1, 16'h8800, 16'h8800, 16'h0400, 16'h0400, 1'b0);

        // Idle cycle: valid drops, result holds the last value.
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'h7000;
        b        = 16'h7000;
        @(posedge clk);
        #2;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_result_hold", 32'(result), 32'(last_res));
        check("idle_ovf_hold", 32'(ovf), 32'd0);

        // Three back-to-back ops; reset asserted during the second discards it.
        issue(1'b1, 16'h1800, 16'h2000, 16'h3000, 16'h3000, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        op       = 1'b0;
        a        = 16'h1000;
        b        = 16'h1000;
        rst_n    = 1'b0;
        @(posedge clk);
        #2;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", 32'(result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        op = 1'b0;
        a = 16'h1000;
        b = 16'h9800;
        begin
            exp_t e;
            e.res = 16'h8800;
            e.ovf = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;

        repeat (4) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
